// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out frame transmitter.
// Sends one DATA_W-bit word as start bit (0), data bits LSB first, stop bit (1),
// each line bit held for CLKS_PER_BIT clocks. All outputs come straight from
// flops so the line can drive a pin or a downstream receiver directly.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy
);

  // Counter widths never drop below one bit so degenerate parameters still elaborate.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CLK_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]        state_q,    state_d;
  logic [CNT_W-1:0]  clk_cnt_q,  clk_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [DATA_W-1:0] shift_q,    shift_d;
  logic              tx_out_q,   tx_out_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q,     busy_d;

  logic              clk_last;
  logic              bit_last;
  logic [DATA_W-1:0] shift_next;

  assign clk_last   = (clk_cnt_q == CLK_LAST);
  assign bit_last   = (bit_cnt_q == BIT_LAST);
  assign shift_next = shift_q >> 1;

  // Next-state logic: the line value is computed one cycle ahead so tx_out is a flop.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_out_d  = tx_out_q;

    case (state_q)
      ST_IDLE: begin
        tx_out_d = 1'b1;
        // tx_ready_q is high throughout IDLE; using it keeps the handshake
        // defined by the registered ready the sender actually sees.
        if (tx_valid && tx_ready_q) begin
          shift_d   = tx_data;
          state_d   = ST_START;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          tx_out_d  = 1'b0;
        end
      end

      ST_START: begin
        if (clk_last) begin
          state_d   = ST_DATA;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          tx_out_d  = shift_q[0];
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (clk_last) begin
          clk_cnt_d = '0;
          shift_d   = shift_next;
          if (bit_last) begin
            state_d  = ST_STOP;
            tx_out_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            tx_out_d  = shift_next[0];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        tx_out_d = 1'b1;
        if (clk_last) begin
          state_d   = ST_IDLE;
          clk_cnt_d = '0;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        tx_out_d  = 1'b1;
      end
    endcase

    // Ready and busy follow the next state so both are registered and complementary.
    tx_ready_d = (state_d == ST_IDLE);
    busy_d     = ~tx_ready_d;
  end

  // State registers; reset aborts any frame in flight without a stop bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_out_q   <= tx_out_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (4 and 1 clocks per bit) share one stimulus
// stream and are compared every cycle against a frame-position reference model.
module tb_serial_tx;

  localparam int DW = 8;
  localparam int C0 = 4;
  localparam int C1 = 1;
  localparam int L0 = (DW + 2) * C0;
  localparam int L1 = (DW + 2) * C1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          rdy0, out0, busy0;
  logic          rdy1, out1, busy1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(C0)) u_dut4 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy0), .tx_out(out0), .busy(busy0)
  );

  serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(C1)) u_dut1 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy1), .tx_out(out1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  // Line value at sample k of a frame: slot 0 start, slots 1..DW data LSB first, then stop.
  function automatic logic frame_bit(input logic [DW-1:0] d, input int c, input int k);
    int slot;
    logic [DW-1:0] t;
    slot = k / c;
    if (slot == 0) return 1'b0;
    if (slot <= DW) begin
      t = d >> (slot - 1);
      return t[0];
    end
    return 1'b1;
  endfunction

  // Reference model: pos = -1 when idle, else clock index into the current frame.
  int pos0 = -1;
  int pos1 = -1;
  logic [DW-1:0] md0 = '0;
  logic [DW-1:0] md1 = '0;

  always @(posedge clk) begin
    if (!reset) pos0 <= -1;
    else if (pos0 < 0) begin
      if (tx_valid) begin pos0 <= 0; md0 <= tx_data; end
    end else if (pos0 == L0 - 1) pos0 <= -1;
    else pos0 <= pos0 + 1;
  end

  always @(posedge clk) begin
    if (!reset) pos1 <= -1;
    else if (pos1 < 0) begin
      if (tx_valid) begin pos1 <= 0; md1 <= tx_data; end
    end else if (pos1 == L1 - 1) pos1 <= -1;
    else pos1 <= pos1 + 1;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic e0, e1;
    e0 = (pos0 < 0) ? 1'b1 : frame_bit(md0, C0, pos0);
    e1 = (pos1 < 0) ? 1'b1 : frame_bit(md1, C1, pos1);
    chk("c4_out",  32'(out0),  32'(e0));
    chk("c4_rdy",  32'(rdy0),  32'(pos0 < 0));
    chk("c4_busy", 32'(busy0), 32'(pos0 >= 0));
    chk("c1_out",  32'(out1),  32'(e1));
    chk("c1_rdy",  32'(rdy1),  32'(pos1 < 0));
    chk("c1_busy", 32'(busy1), 32'(pos1 >= 0));
  end

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while (!(rdy0 && rdy1) && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 500) chk("idle_timeout", 32'(0), 32'(1));
  endtask

  task automatic send(input logic [DW-1:0] d);
    wait_idle();
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    int cnt;

    // Reset held two clocks with valid asserted: no frame may start.
    reset    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'($urandom);
    repeat (2) @(negedge clk);
    chk("rst_rdy",  32'(rdy0),  32'(1));
    chk("rst_out",  32'(out0),  32'(1));
    chk("rst_busy", 32'(busy0), 32'(0));
    tx_valid = 1'b0;
    reset    = 1'b1;
    repeat (3) @(negedge clk);

    // Single 0xA5 frame; ready must be low for the whole frame.
    send(8'hA5);
    cnt = 1;
    while (!rdy0 && cnt < 200) begin
      @(negedge clk);
      if (!rdy0) cnt++;
    end
    chk("a5_ready_low", 32'(cnt), 32'(L0));

    // Word change while busy must not disturb the frame on the line.
    send(8'h3C);
    repeat (12) @(negedge clk);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    cnt = 0;
    while (!rdy0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 200) chk("busy_timeout", 32'(0), 32'(1));
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle();

    // Back-to-back frames with valid held high.
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'hFF;
    cnt = 1;
    while (!rdy0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("b2b_period", 32'(cnt), 32'(L0 + 1));
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle();

    // Reset during data bit 3 of 0x55, then a clean 0x81 frame.
    send(8'h55);
    repeat (17) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_rdy",  32'(rdy0),  32'(1));
    chk("midrst_out",  32'(out0),  32'(1));
    chk("midrst_busy", 32'(busy0), 32'(0));
    reset = 1'b1;
    send(8'h81);
    wait_idle();

    // One clock per bit: 0x01 frame, ready low for ten clocks.
    send(8'h01);
    cnt = 1;
    while (!rdy1 && cnt < 200) begin
      @(negedge clk);
      if (!rdy1) cnt++;
    end
    chk("c1_ready_low", 32'(cnt), 32'(L1));
    wait_idle();

    // Randomized traffic with occasional resets.
    repeat (600) begin
      tx_valid = ($urandom % 4) == 0;
      tx_data  = 8'($urandom);
      reset    = ($urandom % 97) != 0;
      @(negedge clk);
    end
    reset    = 1'b1;
    tx_valid = 1'b0;
    wait_idle();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
